// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST controller: FSM state encoding,
// the default pattern seed, and the drain counter width.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Counts DRAIN cycles; read latency never exceeds 3.
  localparam int unsigned DRAIN_CNT_W = 2;

endpackage

// File: rtl/mem_bist_cmp_pipe.sv
// Delay line carrying expected data and address alongside outstanding RAM
// reads, so each returning word meets its own expected value.
// Ports:
//   clk, rst_n            clock / async active-low reset (flushes the line)
//   in_valid/addr/exp     read issued this cycle
//   out_valid/addr/exp    read whose data is on mem_dout this cycle
// RD_LAT = 0 makes the line a straight wire (combinational RAM read).
module mem_bist_cmp_pipe
  import mem_bist_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);

  generate
    if (RD_LAT == 0) begin : g_comb
      assign out_valid = in_valid;
      assign out_addr  = in_addr;
      assign out_exp   = in_exp;
    end else begin : g_reg
      logic              vld_q  [RD_LAT];
      logic [ADDR_W-1:0] addr_q [RD_LAT];
      logic [DATA_W-1:0] exp_q  [RD_LAT];

      // Shift register, stage 0 takes the newly issued read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(RD_LAT); i++) begin
            vld_q[i]  <= 1'b0;
            addr_q[i] <= '0;
            exp_q[i]  <= '0;
          end
        end else begin
          vld_q[0]  <= in_valid;
          addr_q[0] <= in_addr;
          exp_q[0]  <= in_exp;
          for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
          end
        end
      end

      assign out_valid = vld_q[RD_LAT-1];
      assign out_addr  = addr_q[RD_LAT-1];
      assign out_exp   = exp_q[RD_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes addr^SEED to every RAM location, reads
// everything back, and reports pass / first failing address / error count.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   start             one-cycle run request (ignored while busy)
//   mem_wen/addr/din  RAM write enable, address, write data
//   mem_dout          RAM read data, valid RD_LAT cycles after the address
//   busy, done, pass  run status; pass valid while done=1
//   fail_addr         address of the first mismatch of the run
//   err_cnt           mismatch count, saturating at 255
// Build option: define MEM_BIST_INV_PASS_EN to add a second pass with
// inverted data ~(addr^SEED) before DONE.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter logic [7:0]  SEED   = DEFAULT_SEED,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        err_cnt
);

  localparam int unsigned PAT_W = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Pattern for one address: addr^SEED truncated to the data width.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [PAT_W-1:0] x;
    x = PAT_W'(a) ^ PAT_W'(SEED);
    return DATA_W'(x);
  endfunction

  state_t                 state_q, state_d;
  state_t                 pass_end_c;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q;
  logic                   addr_last_c;
  logic                   start_ok_c;
  logic [ADDR_W-1:0]      addr_next_c;
  logic [DATA_W-1:0]      din_next_c;
  logic [DATA_W-1:0]      exp_issue_c;
  logic                   issue_c;
  logic                   cmp_valid_c;
  logic [ADDR_W-1:0]      cmp_addr_c;
  logic [DATA_W-1:0]      cmp_exp_c;
  logic                   mismatch_c;

  assign addr_last_c = (mem_addr == ADDR_MAX);
  assign start_ok_c  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign issue_c     = (state_q == ST_READ);
  // Address walks only in WRITE/READ and wraps to 0 at each phase end.
  assign addr_next_c = ((state_q == ST_WRITE) || (state_q == ST_READ)) ?
                       (mem_addr + ADDR_W'(1)) : '0;

`ifdef MEM_BIST_INV_PASS_EN
  logic inv_q, inv_d;

  assign pass_end_c = inv_q ? ST_DONE : ST_WRITE;

  // Entering WRITE from the end of a pass selects the inverted pass.
  always_comb begin
    inv_d = inv_q;
    if ((state_d == ST_WRITE) && (state_q != ST_WRITE)) begin
      inv_d = (state_q == ST_READ) || (state_q == ST_DRAIN);
    end
  end

  assign din_next_c  = pattern(addr_next_c) ^ {DATA_W{inv_d}};
  assign exp_issue_c = pattern(mem_addr) ^ {DATA_W{inv_q}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`else
  assign pass_end_c  = ST_DONE;
  assign din_next_c  = pattern(addr_next_c);
  assign exp_issue_c = pattern(mem_addr);
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_WRITE;
      ST_WRITE:         if (addr_last_c) state_d = ST_READ;
      ST_READ:          if (addr_last_c) state_d = (RD_LAT == 0) ? pass_end_c : ST_DRAIN;
      ST_DRAIN:         if (drain_cnt_q == DRAIN_CNT_W'(RD_LAT - 1)) state_d = pass_end_c;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  mem_bist_cmp_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_c),
    .in_addr   (mem_addr),
    .in_exp    (exp_issue_c),
    .out_valid (cmp_valid_c),
    .out_addr  (cmp_addr_c),
    .out_exp   (cmp_exp_c)
  );

  assign mismatch_c = cmp_valid_c && (mem_dout != cmp_exp_c);

  // RAM drive, drain counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      drain_cnt_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      err_cnt     <= '0;
    end else begin
      mem_wen     <= (state_d == ST_WRITE);
      mem_addr    <= addr_next_c;
      mem_din     <= (state_d == ST_WRITE) ? din_next_c : '0;
      drain_cnt_q <= (state_q == ST_DRAIN) ? (drain_cnt_q + DRAIN_CNT_W'(1)) : '0;

      if (start_ok_c) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        pass      <= 1'b0;
        fail_addr <= '0;
        err_cnt   <= '0;
      end else begin
        if (mismatch_c) begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (err_cnt == 8'h00) fail_addr <= cmp_addr_c;
        end
        // The final compare lands on the same edge that enters DONE.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_cnt == 8'h00) && !mismatch_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl at default parameters with a RAM
// model (sync write, one-cycle read) that can hold a stuck-at-0 cell or
// return all zeros. Honours MEM_BIST_INV_PASS_EN.
module tb_mem_bist_ctrl;

  localparam int N = 128;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int RUN_LEN = PASSES * (2 * N + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mem_wen;
  logic [6:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy, done, pass;
  logic [6:0] fail_addr;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // RAM fault configuration
  bit   zero_mode = 1'b0;
  bit   fault_en  = 1'b0;
  int   fault_addr = 0;
  int   fault_bit  = 0;

  logic [7:0] ram [N];
  logic [7:0] rd_q;

  always #5 clk = ~clk;

  mem_bist_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .err_cnt   (err_cnt)
  );

  // RAM: stuck-at-0 cell applied at write, read data one cycle after address.
  always @(posedge clk) begin
    if (mem_wen) begin
      if (fault_en && (int'(mem_addr) == fault_addr))
        ram[mem_addr] <= mem_din & ~(8'd1 << fault_bit);
      else
        ram[mem_addr] <= mem_din;
    end
    rd_q <= ram[mem_addr];
  end
  assign mem_dout = zero_mode ? 8'h00 : rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a full run should report for the current RAM faults.
  task automatic model(output int err, output int faddr);
    logic [7:0] p, stored, rd;
    bit first;
    err = 0; faddr = 0; first = 1'b1;
    for (int ps = 0; ps < PASSES; ps++) begin
      for (int a = 0; a < N; a++) begin
        p = 8'(a) ^ 8'hA5;
        if (ps == 1) p = ~p;
        stored = (fault_en && a == fault_addr) ? (p & ~(8'd1 << fault_bit)) : p;
        rd = zero_mode ? 8'h00 : stored;
        if (rd != p) begin
          err++;
          if (first) begin faddr = a; first = 1'b0; end
        end
      end
    end
    if (err > 255) err = 255;
  endtask

  // Pulses start at a negedge, runs to completion, checks everything.
  // restart_at < 0 means no extra start pulse during the run.
  task automatic run_test(input string name, input int restart_at);
    int exp_err, exp_fa, cyc, wen_cnt;
    logic [7:0] w0 [$];
    model(exp_err, exp_fa);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy_rise"}, 32'(busy), 32'd1);
    chk({name, ".done_clr"}, 32'(done), 32'd0);
    chk({name, ".first_addr"}, 32'(mem_addr), 32'd0);
    cyc = 0; wen_cnt = 0;
    while (busy === 1'b1 && cyc < 4 * RUN_LEN) begin
      if (mem_wen) wen_cnt++;
      if (mem_wen && mem_addr == 7'd0) w0.push_back(mem_din);
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, ".busy_len"}, 32'(cyc), 32'(RUN_LEN));
    chk({name, ".wen_cycles"}, 32'(wen_cnt), 32'(PASSES * N));
    chk({name, ".addr0_writes"}, 32'(w0.size()), 32'(PASSES));
    if (w0.size() > 0) chk({name, ".addr0_p1"}, 32'(w0[0]), 32'h0A5);
    if (w0.size() > 1) chk({name, ".addr0_p2"}, 32'(w0[1]), 32'h05A);
    chk({name, ".done"}, 32'(done), 32'd1);
    chk({name, ".pass"}, 32'(pass), 32'(exp_err == 0));
    chk({name, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({name, ".fail_addr"}, 32'(fail_addr), 32'(exp_fa));
    repeat (3) @(negedge clk);
    chk({name, ".done_hold"}, 32'(done), 32'd1);
    chk({name, ".err_hold"}, 32'(err_cnt), 32'(exp_err));
    chk({name, ".wen_idle"}, 32'(mem_wen), 32'd0);
  endtask

  initial begin
    int ra;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.wen", 32'(mem_wen), 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.din", 32'(mem_din), 32'd0);
    chk("rst.err", 32'(err_cnt), 32'd0);
    chk("rst.fail_addr", 32'(fail_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal RAM
    run_test("ideal", -1);

    // Stuck bit 3 at address 12 (pattern 8'hA9 has bit 3 set)
    fault_en = 1'b1; fault_addr = 12; fault_bit = 3;
    run_test("stuck12", -1);
    fault_en = 1'b0;

    // RAM always reads zero
    zero_mode = 1'b1;
    run_test("zeros", -1);
    zero_mode = 1'b0;

    // Second start during the run is ignored
    run_test("restart100", 100);

    // Reset in the middle of WRITE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.wen", 32'(mem_wen), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.addr", 32'(mem_addr), 32'd0);
    chk("midrst.err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Start coincides with the first rising edge after reset release.
    run_test("after_rst", -1);

    // Randomized stuck cells and restart points
    for (int k = 0; k < 4; k++) begin
      fault_en   = 1'b1;
      fault_addr = int'($urandom_range(N - 1, 0));
      fault_bit  = int'($urandom_range(7, 0));
      ra         = int'($urandom_range(RUN_LEN - 2, 1));
      run_test($sformatf("rnd%0d_a%0d_b%0d", k, fault_addr, fault_bit), ra);
    end
    fault_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, RAM address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter SEED, default 8'hA5, pattern seed XORed with the address.
REQ-004 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles, legal values 0..3.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to run the test.
REQ-008 SHALL have port mem_wen  output  1  RAM write enable.
REQ-009 SHALL have port mem_addr  output  ADDR_W  RAM address.
REQ-010 SHALL have port mem_din  output  DATA_W  RAM write data.
REQ-011 SHALL have port mem_dout  input  DATA_W  RAM read data.
REQ-012 SHALL have port busy  output  1  test in progress.
REQ-013 SHALL have port done  output  1  test finished; results valid.
REQ-014 SHALL have port pass  output  1  no mismatch found; valid while done=1.
REQ-015 SHALL have port fail_addr  output  ADDR_W  address of the first mismatch.
REQ-016 SHALL have port err_cnt  output  8  mismatch count, saturating at 255.

Function
REQ-017 SHALL implement the FSM IDLE -> WRITE -> READ -> DRAIN -> DONE; DONE -> WRITE on start.
REQ-018 SHALL leave IDLE or DONE on the edge where start=1, clear pass, fail_addr, err_cnt and done, and raise busy.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL, in WRITE, drive mem_wen=1, mem_addr=0..2**ADDR_W-1 (one per cycle) and mem_din=addr^SEED (truncated to DATA_W).
REQ-021 SHALL, in READ, drive mem_wen=0 and mem_addr=0..2**ADDR_W-1 (one per cycle) with no gap after WRITE.
REQ-022 SHALL compare mem_dout against the expected value for the address issued RD_LAT cycles earlier, using an RD_LAT-deep pipeline of expected data and address. For RD_LAT=0 the comparison SHALL be made in the same cycle.
REQ-023 SHALL stay in DRAIN for RD_LAT cycles (skipped when RD_LAT=0) until the last compare completes.
REQ-024 SHALL, on a mismatch, increment err_cnt (holding at 255) and capture fail_addr only on the first mismatch of the run.
REQ-025 SHALL, on entering DONE, set done=1, busy=0 and pass=(err_cnt==0). These values SHALL hold until the next start.
REQ-026 SHALL hold busy=1 for exactly 2*2**ADDR_W+RD_LAT cycles per pass (257 at defaults).
REQ-027 SHALL hold mem_wen=0 in every state except WRITE.
REQ-028 SHALL wrap mem_addr from its maximum to 0 between phases without overflow side effects.

Reset
REQ-029 SHALL, on rst_n=0, immediately force the FSM to IDLE and set mem_wen, mem_addr, mem_din, busy, done, pass, fail_addr and err_cnt to 0. This SHALL also apply mid-test.
REQ-030 SHALL discard any compare pipeline contents on reset.
REQ-031 SHALL resume operation on the first rising clk edge after rst_n deasserts; a start at that edge SHALL be accepted.

Configuration
REQ-032 SHALL, when MEM_BIST_INV_PASS_EN is defined, run a second WRITE/READ/DRAIN pass with data ~(addr^SEED) before DONE. Mismatches from both passes SHALL accumulate, and busy SHALL last 2*(2*2**ADDR_W+RD_LAT) cycles.
REQ-033 SHALL, without MEM_BIST_INV_PASS_EN, run the single pass only and contain no second-pass logic.

Structure
REQ-034 SHALL place the FSM state encoding and the default SEED constant in the shared package mem_bist_pkg.
REQ-035 SHALL implement the expected-data/address delay line as the sub-module mem_bist_cmp_pipe, parameterised by RD_LAT.

Verification
REQ-036 Ideal RAM model (sync write, RD_LAT=1), start pulse -> busy high 257 cycles, then done=1, pass=1, err_cnt=0.
REQ-037 RAM model with bit 3 stuck-at-0 at address 12 (expected 12^A5=8'hA9) -> pass=0, fail_addr=12, err_cnt=1.
REQ-038 RAM model returning 8'h00 at all addresses -> err_cnt=128. A pattern byte equals 0 only at address 8'hA5, which is out of range, so every address mismatches.
REQ-039 rst_n pulled low at cycle 40 of WRITE -> mem_wen=0 and busy=0 in the same cycle. A new start then yields a full 257-cycle run with pass=1.
REQ-040 Start pulsed again at cycle 100 of a run -> ignored; busy length unchanged at 257.
REQ-041 With MEM_BIST_INV_PASS_EN defined, ideal RAM -> busy 514 cycles, pass=1; address 0 is written with 8'hA5 and then 8'h5A.
